// File: rtl/dcs_supplier.sv
// Restock supplier: accepts an order, spends qty*COOK_CYC cycles preparing it, then waits for pickup.
// Optional SUPPLIER_STATS_EN builds saturating per-product delivery counters.
module dcs_supplier #(
    parameter int COOK_CYC = 2,
    parameter int MAX_NUM  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        product_in,
    input  logic [5:0]  number_in,
    output logic        ready_out,
    output logic        busy,
    output logic [15:0] served_p1,
    output logic [15:0] served_p0
);

    typedef enum logic [1:0] {IDLE, PREP, READY} state_t;

    localparam logic [5:0] MAX_Q  = 6'(MAX_NUM);
    localparam logic [9:0] COOK_Q = 10'(COOK_CYC);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       prod_q, prod_d;
    logic [5:0] qty_q, qty_d;
    logic [5:0] qty_clamp;
    logic       deliver;

    assign qty_clamp = (number_in > MAX_Q) ? MAX_Q : number_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        qty_d   = qty_q;
        deliver = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    prod_d = product_in;
                    qty_d  = qty_clamp;
                    if (qty_clamp == 6'd0) begin
                        state_d = READY;
                        cnt_d   = 10'd0;
                    end else begin
                        state_d = PREP;
                        cnt_d   = {4'd0, qty_clamp} * COOK_Q - 10'd1;
                    end
                end
            end
            PREP: begin
                // Withdrawal wins over completion.
                if (!valid_in) begin
                    state_d = IDLE;
                    cnt_d   = 10'd0;
                end else if (cnt_q == 10'd0) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            READY: begin
                // ready_out is high here, so valid_in alone decides handshake vs withdrawal.
                state_d = IDLE;
                deliver = valid_in;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 10'd0;
            prod_q  <= 1'b0;
            qty_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            qty_q   <= qty_d;
        end
    end

    assign ready_out = (state_q == READY);
    assign busy      = (state_q != IDLE);

`ifdef SUPPLIER_STATS_EN
    logic [15:0] p1_q, p0_q;
    logic [16:0] sum1, sum0;

    assign sum1 = {1'b0, p1_q} + {11'd0, qty_q};
    assign sum0 = {1'b0, p0_q} + {11'd0, qty_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q <= 16'd0;
            p0_q <= 16'd0;
        end else if (deliver) begin
            if (prod_q) p1_q <= sum1[16] ? 16'hFFFF : sum1[15:0];
            else        p0_q <= sum0[16] ? 16'hFFFF : sum0[15:0];
        end
    end

    assign served_p1 = p1_q;
    assign served_p0 = p0_q;
`else
    logic unused_stats;
    assign unused_stats = ^{deliver, prod_q, qty_q};
    assign served_p1    = 16'd0;
    assign served_p0    = 16'd0;
`endif

endmodule

// File: tb/tb_dcs_supplier.sv
// Directed bench for dcs_supplier: order table plus withdrawal, reset and saturation sequences.
module tb_dcs_supplier;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, product_in;
    logic [5:0]  number_in;
    logic        ready_out, busy;
    logic [15:0] served_p1, served_p0;

    logic        s_rst_n, s_valid, s_prod;
    logic [5:0]  s_num;
    logic        s_ready, s_busy;
    logic [15:0] s_p1, s_p0;

`ifdef SUPPLIER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    dcs_supplier #(.COOK_CYC(2), .MAX_NUM(50)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .product_in(product_in),
        .number_in(number_in), .ready_out(ready_out), .busy(busy),
        .served_p1(served_p1), .served_p0(served_p0)
    );

    // Fast instance used only to reach counter saturation in a reasonable cycle count.
    dcs_supplier #(.COOK_CYC(1), .MAX_NUM(63)) u_sat (
        .clk(clk), .rst_n(s_rst_n), .valid_in(s_valid), .product_in(s_prod),
        .number_in(s_num), .ready_out(s_ready), .busy(s_busy),
        .served_p1(s_p1), .served_p0(s_p0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sx(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    // Place an order, measure cycles from capture edge to ready_out, then hand-shake.
    task automatic run_order(input bit prod, input logic [5:0] num, input int lat,
                             input bit scramble, input string tag);
        int k;
        valid_in = 1'b1; product_in = prod; number_in = num;
        tick();
        chk({tag, " busy@E0"}, 32'(busy), 32'd1);
        if (scramble) begin
            product_in = ~prod;
            number_in  = 6'd20;
        end
        k = 0;
        while (!ready_out && k < 300) begin
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        tick();
        chk({tag, " ready after hs"}, 32'(ready_out), 32'd0);
        chk({tag, " busy after hs"}, 32'(busy), 32'd0);
        valid_in = 1'b0;
        tick();
        chk({tag, " stays idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        bit         prod;
        logic [5:0] num;
        int         lat;
        int         p1;
        int         p0;
    } vec_t;

    vec_t tbl[6];
    int   sat_exp;
    int   sat_to;

    task automatic sat_order(input logic [5:0] n);
        int k;
        s_valid = 1'b1; s_prod = 1'b1; s_num = n;
        tick();
        k = 0;
        while (!s_ready && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) sat_to++;
        tick();
        sat_exp = (sat_exp + int'(n) > 65535) ? 65535 : sat_exp + int'(n);
    endtask

    initial begin
        tbl[0] = '{1'b1, 6'd7,  14,  7,   0};
        tbl[1] = '{1'b0, 6'd0,  0,   7,   0};
        tbl[2] = '{1'b0, 6'd63, 100, 7,   50};
        tbl[3] = '{1'b1, 6'd1,  2,   8,   50};
        tbl[4] = '{1'b0, 6'd50, 100, 8,   100};
        tbl[5] = '{1'b1, 6'd51, 100, 58,  100};

        rst_n = 1'b0; valid_in = 1'b0; product_in = 1'b0; number_in = 6'd0;
        s_rst_n = 1'b0; s_valid = 1'b0; s_prod = 1'b0; s_num = 6'd0;
        #2;
        chk("reset ready", 32'(ready_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset p1", 32'(served_p1), 32'd0);
        chk("reset p0", 32'(served_p0), 32'd0);
        #10;
        rst_n = 1'b1; s_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_order(tbl[i].prod, tbl[i].num, tbl[i].lat, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d p1", i), 32'(served_p1), sx(tbl[i].p1));
            chk($sformatf("vec%0d p0", i), 32'(served_p0), sx(tbl[i].p0));
        end

        // Captured product/qty must govern even if inputs wander mid-order.
        run_order(1'b1, 6'd4, 8, 1'b1, "scramble");
        chk("scramble p1", 32'(served_p1), sx(62));
        chk("scramble p0", 32'(served_p0), sx(100));

        // Withdrawal during PREP.
        valid_in = 1'b1; product_in = 1'b1; number_in = 6'd10;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("wd prep ready low", 32'(ready_out), 32'd0);
            tick();
        end
        valid_in = 1'b0;
        tick();
        chk("wd prep busy", 32'(busy), 32'd0);
        chk("wd prep ready", 32'(ready_out), 32'd0);
        tick();
        chk("wd prep idle", 32'(busy), 32'd0);
        chk("wd prep p1", 32'(served_p1), sx(62));

        // Withdrawal from READY: no delivery.
        valid_in = 1'b1; product_in = 1'b0; number_in = 6'd0;
        tick();
        chk("wd rdy ready", 32'(ready_out), 32'd1);
        valid_in = 1'b0;
        tick();
        chk("wd rdy busy", 32'(busy), 32'd0);
        chk("wd rdy p0", 32'(served_p0), sx(100));

        // Reset mid-PREP, then a capture on the first edge after release.
        valid_in = 1'b1; product_in = 1'b1; number_in = 6'd5;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst prep busy", 32'(busy), 32'd0);
        chk("rst prep p1", 32'(served_p1), 32'd0);
        chk("rst prep p0", 32'(served_p0), 32'd0);
        #2;
        rst_n = 1'b1;
        run_order(1'b0, 6'd3, 6, 1'b0, "post rst");
        chk("post rst p0", 32'(served_p0), sx(3));
        chk("post rst p1", 32'(served_p1), 32'd0);

        // Reset while READY clears outputs without waiting for a clock.
        valid_in = 1'b1; product_in = 1'b1; number_in = 6'd2;
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("pre rst ready", 32'(ready_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst rdy ready", 32'(ready_out), 32'd0);
        chk("rst rdy busy", 32'(busy), 32'd0);
        chk("rst rdy p0", 32'(served_p0), 32'd0);
        valid_in = 1'b0;
        #3;
        rst_n = 1'b1;
        run_order(1'b1, 6'd3, 6, 1'b0, "after rdy rst");
        chk("after rdy rst p1", 32'(served_p1), sx(3));

        // Saturation on the fast instance.
        sat_exp = 0;
        sat_to  = 0;
        for (int i = 0; i < 1040; i++) sat_order(6'd63);
        sat_order(6'd10);
        chk("sat timeouts", 32'(sat_to), 32'd0);
        chk("sat 65530", 32'(s_p1), sx(65530));
        sat_order(6'd10);
        chk("sat model", 32'(sat_exp), 32'd65535);
        chk("sat 65535", 32'(s_p1), sx(65535));
        sat_order(6'd10);
        s_valid = 1'b0;
        tick();
        chk("sat hold", 32'(s_p1), sx(65535));
        chk("sat p0", 32'(s_p0), 32'd0);
        chk("sat busy", 32'(s_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcs_supplier.md
DCS_SUPPLIER -- requirements
Module: dcs_supplier

Interface
REQ-001 Parameter COOK_CYC, default 2, clock cycles to prepare one unit (legal 1..15).
REQ-002 Parameter MAX_NUM, default 50, largest quantity supplied per request.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  requester holds high while a restock request is pending.
REQ-006 product_in  input  1  product address (1 = first product, 0 = second); stable while valid_in high.
REQ-007 number_in  input  6  requested quantity; stable while valid_in high.
REQ-008 ready_out  output  1  high = order prepared; handshake when valid_in && ready_out at a rising edge.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 served_p1  output  16  units delivered for product 1 (statistics feature).
REQ-011 served_p0  output  16  units delivered for product 0 (statistics feature).

Function
REQ-012 FSM states IDLE, PREP, READY; all outputs registered.
REQ-013 IDLE: ready_out=0; on edge E0 with valid_in=1, capture product_in and qty = min(number_in, MAX_NUM).
REQ-014 At E0: qty==0 -> READY; else -> PREP with cnt = qty*COOK_CYC-1 (10-bit cnt, no overflow for 63*15).
REQ-015 PREP: each edge cnt==0 -> READY, else cnt decrements by 1; ready_out rises after edge E0+qty*COOK_CYC.
REQ-016 READY: ready_out held 1 until handshake; handshake edge -> IDLE, ready_out=0 after that edge.
REQ-017 Withdrawal: valid_in=0 sampled in PREP or READY -> IDLE, ready_out=0, nothing delivered, counters unchanged.
REQ-018 New request not accepted on the handshake edge; earliest capture is the edge after returning to IDLE.
REQ-019 product_in/number_in changes during PREP/READY are ignored; captured values govern the order.
REQ-020 On handshake, served counter of captured product += qty, saturating at 16'hFFFF.
REQ-021 ready_out never asserted in IDLE or PREP; busy=1 in PREP and READY.

Reset
REQ-022 rst_n low: state=IDLE, cnt=0, captured product/qty=0, ready_out=0, busy=0, served_p0=served_p1=0, immediately (async).
REQ-023 Reset mid-PREP or mid-READY aborts order; no delivery counted; first capture on first edge with rst_n high and valid_in high.

Configuration
REQ-024 Macro SUPPLIER_STATS_EN defined: served_p0/served_p1 counters built per REQ-020.
REQ-025 Macro SUPPLIER_STATS_EN undefined: no counter registers; served_p0/served_p1 tied to 0; all other behaviour identical.

Verification
REQ-026 COOK_CYC=2, valid_in=1, product_in=1, number_in=7 at E0 -> ready_out high after E14, handshake at E15 -> IDLE, served_p1=7 (STATS on).
REQ-027 number_in=0 -> ready_out high after E0 itself; handshake next edge; served counters unchanged.
REQ-028 number_in=63 -> qty clamped to 50, ready_out after E100, served_p0 += 50 on handshake.
REQ-029 valid_in dropped at cycle 5 of PREP (number_in=10) -> IDLE next edge, ready_out never high, counters 0.
REQ-030 rst_n pulsed low in READY -> ready_out, busy 0 immediately; new request of 3 -> ready after E0+6.
REQ-031 STATS on, served_p1 preloaded to 65530 via repeated orders, order of 10 -> saturates at 65535; STATS off -> outputs stay 0.
